// File: rtl/rarp_rec_if.sv
// Link-side word stream and parsed-field handshake of the RARP receiver.
// The slave modport is the receiver; the master modport is its environment.
interface rarp_rec_if;
  logic [31:0] in_word;
  logic        in_valid;
  logic        in_sop;
  logic        input_hold;

  logic [15:0] hdr_type;
  logic [15:0] proto_type;
  logic [7:0]  hdr_addr_length;
  logic [7:0]  pro_addr_length;
  logic [15:0] operation;
  logic [47:0] send_hdr_addr;
  logic [31:0] send_ip_addr;
  logic [47:0] target_hdr_addr;
  logic [31:0] target_ip_addr;

  logic        output_valid;
  logic        out_ready;
  logic        len_err;
  logic        op_err;
  logic [7:0]  drop_cnt;

  modport slave (
    input  in_word, in_valid, in_sop, out_ready,
    output input_hold,
    output hdr_type, proto_type, hdr_addr_length, pro_addr_length, operation,
    output send_hdr_addr, send_ip_addr, target_hdr_addr, target_ip_addr,
    output output_valid, len_err, op_err, drop_cnt
  );

  modport master (
    output in_word, in_valid, in_sop, out_ready,
    input  input_hold,
    input  hdr_type, proto_type, hdr_addr_length, pro_addr_length, operation,
    input  send_hdr_addr, send_ip_addr, target_hdr_addr, target_ip_addr,
    input  output_valid, len_err, op_err, drop_cnt
  );
endinterface

// File: rtl/rarp_rec.sv
// RARP receiver: reassembles a 7-word RARP/ARP packet, checks lengths/opcode and
// presents the fields with valid/ready. Optional RARP_FILTER_EN keeps only replies to MY_MAC.
module rarp_rec #(
  parameter logic [7:0]  HLEN_EXP = 8'd6,
  parameter logic [7:0]  PLEN_EXP = 8'd4,
  parameter logic [47:0] MY_MAC   = 48'h0000_0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  rarp_rec_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    PRESENT = 2'd2
  } state_e;

  // Field order matches the on-wire word order, so W0..W6 concatenate straight into it.
  typedef struct packed {
    logic [15:0] hdr_type;
    logic [15:0] proto_type;
    logic [7:0]  hlen;
    logic [7:0]  plen;
    logic [15:0] operation;
    logic [47:0] sha;
    logic [31:0] spa;
    logic [47:0] tha;
    logic [31:0] tpa;
  } rarp_pkt_t;

  localparam logic [2:0]  LAST_IDX  = 3'd6;
  localparam logic [15:0] OP_RREQ   = 16'd3;
  localparam logic [15:0] OP_RREPLY = 16'd4;

  state_e      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [31:0] buf_q [0:5];
  logic        buf_we;
  logic [2:0]  buf_waddr;

  rarp_pkt_t   pkt_q, pkt_d, pkt_asm;
  logic        len_err_q, len_err_d;
  logic        op_err_q, op_err_d;
  logic [7:0]  drop_q, drop_d;
  logic        drop_evt;

  logic        accept;
  logic        filter_pass;
  logic        asm_len_err;
  logic        asm_op_err;

  assign accept = bus.in_valid && (state_q != PRESENT);

  // Complete packet as it would look if the current word is W6.
  assign pkt_asm = {buf_q[0], buf_q[1], buf_q[2], buf_q[3], buf_q[4], buf_q[5], bus.in_word};

  assign asm_len_err = (pkt_asm.hlen != HLEN_EXP) || (pkt_asm.plen != PLEN_EXP);
  assign asm_op_err  = (pkt_asm.operation != OP_RREQ) && (pkt_asm.operation != OP_RREPLY);

`ifdef RARP_FILTER_EN
  assign filter_pass = (pkt_asm.operation == OP_RREPLY) && (pkt_asm.tha == MY_MAC);
`else
  logic unused_my_mac;
  assign unused_my_mac = ^MY_MAC;
  assign filter_pass   = 1'b1;
`endif

  // NOTE: combinational blocks use blocking '=' and assign every output a default
  // first; a path that leaves a variable unassigned would infer a latch.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pkt_d     = pkt_q;
    len_err_d = len_err_q;
    op_err_d  = op_err_q;
    drop_evt  = 1'b0;
    buf_we    = 1'b0;
    buf_waddr = idx_q;

    unique case (state_q)
      IDLE: begin
        if (accept && bus.in_sop) begin
          buf_we    = 1'b1;
          buf_waddr = 3'd0;
          idx_d     = 3'd1;
          state_d   = COLLECT;
        end
      end

      COLLECT: begin
        if (accept) begin
          if (bus.in_sop) begin
            // A new start-of-packet abandons the partial one and restarts at W0.
            drop_evt  = 1'b1;
            buf_we    = 1'b1;
            buf_waddr = 3'd0;
            idx_d     = 3'd1;
          end else if (idx_q == LAST_IDX) begin
            idx_d = 3'd0;
            if (filter_pass) begin
              pkt_d     = pkt_asm;
              len_err_d = asm_len_err;
              op_err_d  = asm_op_err;
              state_d   = PRESENT;
            end else begin
              drop_evt = 1'b1;
              state_d  = IDLE;
            end
          end else begin
            buf_we = 1'b1;
            idx_d  = idx_q + 3'd1;
          end
        end
      end

      PRESENT: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        idx_d   = 3'd0;
      end
    endcase

    drop_d = (drop_evt && (drop_q != 8'hFF)) ? drop_q + 8'd1 : drop_q;
  end

  // NOTE: sequential state uses non-blocking '<=' so every register samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= 3'd0;
      pkt_q     <= '0;
      len_err_q <= 1'b0;
      op_err_q  <= 1'b0;
      drop_q    <= 8'd0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      pkt_q     <= pkt_d;
      len_err_q <= len_err_d;
      op_err_q  <= op_err_d;
      drop_q    <= drop_d;
    end
  end

  // NOTE: the word buffer has no reset; idx_q decides which entries are meaningful
  // and nothing reaches the outputs before all of W0..W5 have been rewritten.
  always_ff @(posedge clk) begin
    if (buf_we) begin
      buf_q[buf_waddr] <= bus.in_word;
    end
  end

  assign bus.input_hold      = (state_q == PRESENT);
  assign bus.output_valid    = (state_q == PRESENT);

  assign bus.hdr_type        = pkt_q.hdr_type;
  assign bus.proto_type      = pkt_q.proto_type;
  assign bus.hdr_addr_length = pkt_q.hlen;
  assign bus.pro_addr_length = pkt_q.plen;
  assign bus.operation       = pkt_q.operation;
  assign bus.send_hdr_addr   = pkt_q.sha;
  assign bus.send_ip_addr    = pkt_q.spa;
  assign bus.target_hdr_addr = pkt_q.tha;
  assign bus.target_ip_addr  = pkt_q.tpa;

  assign bus.len_err         = len_err_q;
  assign bus.op_err          = op_err_q;
  assign bus.drop_cnt        = drop_q;

endmodule
